sipo_multichannel: RTL and testbench

- Parametrised successor to the MSDAP stereo serial-in/parallel-out front end.
- Deserialises N synchronous serial channels, each W bits wide, framed by a one-cycle Frame pulse, on the Dclk domain.
- Completed multi-channel words go into a DEPTH-entry output FIFO with a valid/ready handshake, so the filter core can stall without losing samples.
- Adds selectable bit order, detection of a Frame pulse mid-word, and a sticky overrun flag.

---
 rtl/sipo_pkg.sv | 21 ++
 rtl/sipo_word_fifo.sv | 68 ++++++
 rtl/sipo_multichannel.sv | 111 +++++++++++
 tb/tb_sipo_multichannel.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the multichannel serial-in/parallel-out front end.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned W_MAX = 32;
  localparam int unsigned N_MAX = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v * 2) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sipo_word_fifo.sv
// Synchronous word FIFO; head entry is presented combinationally from storage.
module sipo_word_fifo
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             Dclk,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];

  // A push while full is only legal when the head leaves in the same cycle;
  // the write then lands on the slot being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Dclk) begin
    if (clear) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sipo_multichannel.sv
// N-channel serial deserialiser framed by a Frame pulse, feeding a valid/ready
// output FIFO with sticky overrun and mid-word frame error reporting.
module sipo_multichannel
  import sipo_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned N         = 2,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic           Dclk,
  input  logic           clear,
  input  logic           Frame,
  input  logic [N-1:0]   sdata,
  output logic [N*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           overrun,
  output logic           frame_err
);

  localparam int unsigned CW = clog2(W);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [N-1:0][W-1:0]  shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 capture, word_done;
  logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [N*W-1:0]       push_word;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    capture     = 1'b0;
    if (state_q == IDLE) begin
      if (Frame) begin
        state_d = SHIFT;
        count_d = CW'(1);
        capture = 1'b1;
      end
    end else begin
      capture = 1'b1;
      if (Frame) begin
        frame_err_d = 1'b1;
        count_d     = CW'(1);
      end else if (count_q == CW'(W-1)) begin
        word_done = 1'b1;
        state_d   = IDLE;
        count_d   = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // After W shifts every stale bit has left the register, so a restarted word
  // needs no explicit clear of the partial contents.
  always_comb begin
    shreg_d = shreg_q;
    if (capture) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (MSB_FIRST) shreg_d[c] = {shreg_q[c][W-2:0], sdata[c]};
        else           shreg_d[c] = {sdata[c], shreg_q[c][W-1:1]};
      end
    end
  end

  assign push_word = shreg_d;
  assign fifo_pop  = out_ready && !fifo_empty;
  assign fifo_push = word_done && (!fifo_full || fifo_pop);
  assign overrun_d = overrun_q || (word_done && fifo_full && !fifo_pop);

  always_ff @(posedge Dclk) begin
    if (clear) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sipo_word_fifo #(
    .WIDTH (N*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Dclk      (Dclk),
    .clear     (clear),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .head_data (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_multichannel.sv
// Directed bench for sipo_multichannel: MSB-first and LSB-first instances share stimulus.
module tb_sipo_multichannel;

  logic        Dclk = 1'b0;
  logic        clear = 1'b1;
  logic        Frame = 1'b0;
  logic [1:0]  sdata = '0;
  logic        out_ready = 1'b1;

  logic [31:0] out_data, lsb_out_data;
  logic        out_valid, overrun, frame_err;
  logic        lsb_out_valid, lsb_overrun, lsb_frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Dclk = ~Dclk;

  sipo_multichannel #(.W(16), .N(2), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .Dclk(Dclk), .clear(clear), .Frame(Frame), .sdata(sdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  sipo_multichannel #(.W(16), .N(2), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .Dclk(Dclk), .clear(clear), .Frame(Frame), .sdata(sdata),
    .out_data(lsb_out_data), .out_valid(lsb_out_valid), .out_ready(out_ready),
    .overrun(lsb_overrun), .frame_err(lsb_frame_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Dclk);
    #1;
  endtask

  // Sends bits first..last of (l, r) MSB first; Frame accompanies bit 0.
  task automatic send_range(input logic [15:0] l, input logic [15:0] r,
                            input int first, input int last);
    for (int i = first; i <= last; i++) begin
      Frame = (i == 0);
      sdata = {r[15-i], l[15-i]};
      tick();
    end
    Frame = 1'b0;
    sdata = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [15:0] wl(input int i);
    return {4'(i), 12'hABC};
  endfunction

  function automatic logic [15:0] wr(input int i);
    return {12'h5E7, 4'(i)};
  endfunction

  initial begin
    tick();
    tick();
    clear = 1'b0;
    check_eq("reset_valid", 64'(out_valid), 64'd0);
    check_eq("reset_data", 64'(out_data), 64'd0);
    check_eq("reset_overrun", 64'(overrun), 64'd0);
    check_eq("reset_frame_err", 64'(frame_err), 64'd0);

    // sdata toggling while idle must not start a word
    sdata = 2'b11;
    repeat (3) tick();
    sdata = '0;
    check_eq("idle_ignore_valid", 64'(out_valid), 64'd0);

    // Basic word, MSB first and LSB first
    send_range(16'hA5C3, 16'h1234, 0, 14);
    check_eq("lat_before_last", 64'(out_valid), 64'd0);
    send_range(16'hA5C3, 16'h1234, 15, 15);
    check_eq("lat_valid", 64'(out_valid), 64'd1);
    check_eq("msb_data", 64'(out_data), 64'h1234_A5C3);
    check_eq("lsb_valid", 64'(lsb_out_valid), 64'd1);
    check_eq("lsb_data", 64'(lsb_out_data), 64'h2C48_C3A5);
    check_eq("basic_overrun", 64'(overrun), 64'd0);
    tick();
    check_eq("basic_popped", 64'(out_valid), 64'd0);

    // Five back-to-back words into a stalled 4-deep FIFO
    do_clear();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_range(wl(i), wr(i), 0, 15);
    check_eq("ovr_full_no_overrun", 64'(overrun), 64'd0);
    send_range(wl(5), wr(5), 0, 15);
    check_eq("ovr_set", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("ovr_drain_valid", 64'(out_valid), 64'd1);
      check_eq("ovr_drain_data", 64'(out_data), 64'({wr(i), wl(i)}));
      tick();
    end
    check_eq("ovr_drained_empty", 64'(out_valid), 64'd0);
    repeat (3) tick();
    check_eq("ovr_sticky", 64'(overrun), 64'd1);
    do_clear();
    check_eq("ovr_cleared", 64'(overrun), 64'd0);

    // Full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_range(wl(i), wr(i), 0, 15);
    check_eq("pp_full_head", 64'(out_data), 64'({wr(1), wl(1)}));
    send_range(wl(5), wr(5), 0, 14);
    out_ready = 1'b1;
    send_range(wl(5), wr(5), 15, 15);
    out_ready = 1'b0;
    check_eq("pp_no_overrun", 64'(overrun), 64'd0);
    check_eq("pp_head_after", 64'(out_data), 64'({wr(2), wl(2)}));
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check_eq("pp_drain_valid", 64'(out_valid), 64'd1);
      check_eq("pp_drain_data", 64'(out_data), 64'({wr(i), wl(i)}));
      tick();
    end
    check_eq("pp_drained_empty", 64'(out_valid), 64'd0);

    // Frame re-asserted at bit 7
    do_clear();
    out_ready = 1'b1;
    send_range(16'hFFFF, 16'h0F0F, 0, 6);
    send_range(16'h3C96, 16'hE001, 0, 0);
    check_eq("ferr_pulse", 64'(frame_err), 64'd1);
    check_eq("ferr_no_push", 64'(out_valid), 64'd0);
    send_range(16'h3C96, 16'hE001, 1, 1);
    check_eq("ferr_one_cycle", 64'(frame_err), 64'd0);
    send_range(16'h3C96, 16'hE001, 2, 14);
    check_eq("ferr_still_empty", 64'(out_valid), 64'd0);
    send_range(16'h3C96, 16'hE001, 15, 15);
    check_eq("ferr_next_valid", 64'(out_valid), 64'd1);
    check_eq("ferr_next_data", 64'(out_data), 64'hE001_3C96);
    tick();

    // clear mid-word with two words buffered
    do_clear();
    out_ready = 1'b0;
    send_range(wl(7), wr(7), 0, 15);
    send_range(wl(8), wr(8), 0, 15);
    check_eq("clr_two_buffered", 64'(out_valid), 64'd1);
    send_range(wl(9), wr(9), 0, 8);
    clear = 1'b1;
    sdata = 2'b11;
    tick();
    clear = 1'b0;
    sdata = '0;
    check_eq("clr_valid_low", 64'(out_valid), 64'd0);
    check_eq("clr_data_zero", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    send_range(16'h8001, 16'h7FFE, 0, 0);
    check_eq("clr_restart_no_ferr", 64'(frame_err), 64'd0);
    send_range(16'h8001, 16'h7FFE, 1, 14);
    check_eq("clr_lat_before", 64'(out_valid), 64'd0);
    send_range(16'h8001, 16'h7FFE, 15, 15);
    check_eq("clr_lat_valid", 64'(out_valid), 64'd1);
    check_eq("clr_word_data", 64'(out_data), 64'h7FFE_8001);
    check_eq("clr_lsb_data", 64'(lsb_out_data), 64'h7FFE_8001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
